// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared width, counter width and FSM state encoding for the multiply/divide sequencer
package muldiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = $clog2(MD_WIDTH);
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX, MD_DONE} md_state_t;
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: shared adder plus 2*WIDTH shift register; load latches magnitudes ma/mb, step runs one shift-add (MULT) or restoring-divide (DIV) iteration; prod = raw product, quo/rem = raw quotient/remainder
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   ma,
  input  logic [WIDTH-1:0]   mb,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quo,
  output logic [WIDTH-1:0]   rem
);
  logic [WIDTH-1:0] m;
  logic [WIDTH:0] opx, opy, sum;
  logic qb;
  assign opx = is_div ? {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]} : {1'b0, prod[2*WIDTH-1:WIDTH]};
  assign opy = is_div ? ~{1'b0, m} : {1'b0, m};
  assign sum = opx + opy + {{WIDTH{1'b0}}, is_div};
  assign qb = !sum[WIDTH];
  assign quo = prod[WIDTH-1:0];
  assign rem = prod[2*WIDTH-1:WIDTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m <= '0;
      prod <= '0;
    end else if (load) begin
      m <= is_div ? mb : ma;
      prod <= {{WIDTH{1'b0}}, is_div ? ma : mb};
    end else if (step) begin
      prod <= is_div ? {qb ? sum[WIDTH-1:0] : opx[WIDTH-1:0], prod[WIDTH-2:0], qb}
                     : (prod[0] ? {sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]});
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle signed MULT/DIV into HI/LO; start/is_div/flush/opa/opb in, stall/busy/done/hi/lo out
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic             flush,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  md_state_t state;
  logic [CW-1:0] cnt;
  logic div_r, sa, sb, bz, accept;
  logic [WIDTH-1:0] a_r, ma, mb, quo, rem, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod, p_fix;
  assign accept = state == MD_IDLE && start && !flush;
  assign stall = accept || state == MD_CALC || state == MD_FIX;
  assign ma = opa[WIDTH-1] ? -opa : opa;
  assign mb = opb[WIDTH-1] ? -opb : opb;
  assign p_fix = (sa ^ sb) ? -prod : prod;
  assign q_fix = (sa ^ sb) ? -quo : quo;
  assign r_fix = sa ? -rem : rem;
  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .step   (state == MD_CALC && !flush),
    .is_div (accept ? is_div : div_r),
    .ma     (ma),
    .mb     (mb),
    .prod   (prod),
    .quo    (quo),
    .rem    (rem)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MD_IDLE;
      cnt <= '0;
      div_r <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      bz <= 1'b0;
      a_r <= '0;
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (flush) begin
      state <= MD_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: if (start) begin
          div_r <= is_div;
          sa <= opa[WIDTH-1];
          sb <= opb[WIDTH-1];
          bz <= opb == '0;
          a_r <= opa;
          cnt <= '0;
          busy <= 1'b1;
          state <= MD_CALC;
        end
        MD_CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= MD_FIX;
        end
        MD_FIX: begin
          {hi, lo} <= !div_r ? p_fix : bz ? {a_r, {WIDTH{1'b1}}} : {r_fix, q_fix};
          busy <= 1'b0;
          done <= 1'b1;
          state <= MD_DONE;
        end
        default: begin
          done <= 1'b0;
          state <= MD_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic is_div = 1'b0;
  logic flush = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic stall, busy, done;
  logic [31:0] hi, lo;
  int n_assert = 0;
  int n_fail = 0;
  muldiv_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .is_div (is_div),
    .flush  (flush),
    .opa    (opa),
    .opb    (opb),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic d,
                        input logic [31:0] eh, input logic [31:0] el, input logic hold);
    int n;
    logic low;
    opa = a;
    opb = b;
    is_div = d;
    start = 1'b1;
    #1;
    chk({tag, " stall_accept"}, stall, 1);
    n = 0;
    low = 1'b0;
    while (!done && n < 40) begin
      tick();
      n++;
      if (!done && !stall) low = 1'b1;
    end
    chk({tag, " done_cycle"}, n, 34);
    chk({tag, " stall_mid"}, low, 0);
    chk({tag, " stall_done"}, stall, 0);
    chk({tag, " hi"}, hi, eh);
    chk({tag, " lo"}, lo, el);
    if (!hold) start = 1'b0;
    tick();
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " no_reaccept"}, busy, 0);
    start = 1'b0;
    tick();
    chk({tag, " idle_busy"}, busy, 0);
  endtask
  initial begin
    int dn;
    #2;
    chk("rst stall", stall, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst hilo", {hi, lo}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("mult 7x-3", 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult min^2", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0, 1'b0);
    run_op("div 100/7", 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    run_op("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0);
    run_op("div 5/0 hold", 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("div 5/2", 32'd5, 32'd2, 1'b1, 32'd1, 32'd2, 1'b0);
    opa = 32'd100;
    opb = 32'd7;
    is_div = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    start = 1'b0;
    tick();
    flush = 1'b0;
    chk("flush busy", busy, 0);
    chk("flush stall", stall, 0);
    chk("flush hilo", {hi, lo}, {32'd1, 32'd2});
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dn++;
    end
    chk("flush no_done", dn, 0);
    chk("flush hilo_late", {hi, lo}, {32'd1, 32'd2});
    opa = 32'd100;
    opb = 32'd7;
    is_div = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    #2;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("areset busy", busy, 0);
    chk("areset stall", stall, 0);
    chk("areset hilo", {hi, lo}, 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("mult 3x4", 32'd3, 32'd4, 1'b0, 32'd0, 32'd12, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end
endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle signed multiply/divide unit with HI/LO result registers for the single-cycle core. It replaces a combinational multiply/divide path: the control unit raises `start` for MULT/DIV/modulus, and this block stalls the PC for the iteration. It computes the result in 32 shift/add steps, then writes HI/LO, which mfhi/mflo and the modulus write-back read.

## Interface
- `WIDTH`, 32, operand and HI/LO width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request from control unit (decoded `wehilo`); level, held while instruction is stalled.
- `is_div`  in  1  0 = MULT, 1 = DIV (control unit `multdiv`).
- `flush`  in  1  synchronous abort; highest priority after reset.
- `opa`, `opb`  in  WIDTH  signed operands (rs, rt), sampled on accept.
- `stall`  out  1  freeze PC/register-file writes.
- `busy`  out  1  iteration in progress.
- `done`  out  1  one-cycle pulse; HI/LO valid.
- `hi`, `lo`  out  WIDTH  result registers.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start`=1 accepts the request: latch `is_div`, the original operands, the operand signs, and `|opa|`, `|opb|`.
  - Clear the iteration counter, then go to CALC.
- CALC runs exactly WIDTH cycles, counter 0..WIDTH-1, then goes to FIX.
  - MULT: unsigned shift-add on a 2·WIDTH product register, one multiplier bit per cycle, LSB first.
  - DIV: restoring division; WIDTH+1-bit partial remainder; one quotient bit per cycle, MSB first.
- FIX applies signs and writes HI/LO, then goes to DONE.
  - MULT: negate the 2·WIDTH product if the operand signs differ. HI = upper half, LO = lower half.
  - DIV: LO = quotient, negated if the signs differ. HI = remainder, carrying the dividend's sign (truncating division).
  - DIV with `opb`=0 skips the sign fix: LO = all ones, HI = original `opa`.
  - DIV with `opa`=−2^(WIDTH−1) and `opb`=−1 gives LO = 0x80000000, HI = 0. This falls out of the magnitude path; no special case.
- DONE drives `done`=1, ignores `start`, then returns to IDLE.
  - Ignoring `start` here prevents a re-trigger by the still-decoded instruction.
- `start` while in CALC/FIX/DONE is ignored; the operands are not re-sampled.
- `flush`=1 in any state returns the FSM to IDLE next edge.
  - HI/LO stay unchanged; no `done` pulse.
  - `flush` and `start` together in IDLE: no accept.
- Reset mid-operation returns to IDLE; HI/LO are cleared.

## Timing
- Reset values: state IDLE, `stall`=0, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0.
- `stall` = (IDLE & `start` & !`flush`) | CALC | FIX. It is combinational so the accepting cycle is frozen too; `stall`=0 in DONE.
- `busy` = CALC | FIX, registered state decode.
- Latency, with accept at edge 0:
  - `busy` is high in cycles 1..WIDTH+1.
  - HI/LO update at edge WIDTH+2.
  - `done` is high in cycle WIDTH+2, i.e. cycle 34 for WIDTH=32.
  - A new accept is possible at cycle WIDTH+3 at the earliest.
- HI/LO change only at the FIX→DONE edge. Mid-operation reads return the previous result; the core is stalled anyway.
- Back-to-back operations: the next `start` accepted in IDLE after DONE has full latency, with no overlap.

## Structure
- Package `muldiv_pkg`: `WIDTH` default, state enum (`MD_IDLE`, `MD_CALC`, `MD_FIX`, `MD_DONE`), counter width `$clog2(WIDTH)`.
- Sub-module `muldiv_iter_core`: shared WIDTH+1-bit adder/subtractor plus the 2·WIDTH shift register.
  - Inputs: `load`, `step`, `is_div`, magnitudes.
  - Outputs: raw product, or raw quotient and remainder.
- The top level holds the FSM, sign capture/fix, HI/LO registers, and `stall`/`done` logic.

## Test plan
- MULT 7 × −3: at cycle 34, `done`=1, HI=0xFFFFFFFF, LO=0xFFFFFFEB; `stall` high cycles 0..33, low at 34.
- MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0. DIV 100 / 7 → LO=14, HI=2.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIV 5 / 0 → LO=0xFFFFFFFF, HI=5. `start` held high through DONE → exactly one `done` pulse, no re-accept in the DONE cycle.
- `start` accepted with HI/LO=(1,2), then `flush` at cycle 10 → IDLE at cycle 11, `stall`=0, HI/LO remain (1,2), no `done`.
- `rst_n` low asynchronously at cycle 15 → `busy`=0, `stall`=0, `hi`=`lo`=0 immediately. A fresh MULT 3 × 4 after release gives LO=12, `done` 34 cycles after accept.
